spw_link_fsm: RTL and testbench
===============================

// Module: spw_link_fsm
// PURPOSE
//  ECSS-E-ST-50-12C link-interface state machine sequencing the SpaceWire receiver and transmitter.
//  Consumes RX event pulses (null/fct/nchar/time-code/error/bit), drives the RX reset and TX mode,
//  and keeps the TX flow-control credit. Sits between the RX_SPW decoder, the TX encoder and host config.
// PARAMETERS
//  T_6U4     640   pclk cycles for 6.4 us (ERROR_RESET dwell)
//  T_12U8    1280  pclk cycles for 12.8 us (ERROR_WAIT dwell, STARTED/CONNECTING timeout)
//  T_DISC    85    pclk cycles without rx_got_bit before disconnect (850 ns)
//  MAX_CRED  56    TX credit ceiling, in N-Chars
// PORTS
//  pclk             in   1  system clock
//  resetn           in   1  asynchronous active-low reset
//  link_start       in   1  host: start link (level)
//  auto_start       in   1  host: start on first received NULL (level)
//  link_disable     in   1  host: force link down (level)
//  rx_got_bit       in   1  bit-activity pulse, one pclk cycle
//  rx_got_null/_fct/_nchar/_time_code  in 1 each  RX event pulses, one pclk cycle
//  rx_error         in   1  RX parity/escape error pulse
//  tx_nchar_sent    in   1  TX consumed one credit (pulse)
//  rx_resetn        out  1  RX decoder reset, active low
//  tx_enable        out  1  TX running
//  tx_send_fct      out  1  TX may send FCTs (0: NULLs only)
//  tx_credit        out  6  remaining TX credit
//  link_state       out  3  current state encoding
//  link_error       out  1  one-cycle pulse on error-caused entry to ERROR_RESET
// BEHAVIOUR
//  All RX inputs are already synchronized single-cycle pulses in the pclk domain.
//  Reset: state=ERROR_RESET(0), rx_resetn=0, tx_enable=0, tx_send_fct=0, tx_credit=0, link_error=0.
//  States: ERROR_RESET=0, ERROR_WAIT=1, READY=2, STARTED=3, CONNECTING=4, RUN=5; 6,7 -> ERROR_RESET.
//  Timer: one up-counter, cleared on every state change; "expiry" = count==T-1; move on next edge.
//  null_seen flag: set by rx_got_null outside ERROR_RESET, cleared in ERROR_RESET.
//  Disconnect: armed while null_seen; idle counter cleared by rx_got_bit; reaching T_DISC-1 -> disc.
//  err = rx_error | disc | credit violation.
//  ERROR_RESET: rx_resetn=0, TX off, credit cleared; after T_6U4 -> ERROR_WAIT.
//  ERROR_WAIT: rx_resetn=1; err|got_fct|got_nchar|got_time_code -> ERROR_RESET; after T_12U8 -> READY.
//  READY: err|fct|nchar|tc -> ERROR_RESET; link_en=!link_disable&(link_start|(auto_start&null_seen))
//    -> STARTED.
//  STARTED: tx_enable=1, NULLs only; err|fct|nchar|tc|T_12U8 expiry -> ERROR_RESET;
//    null_seen -> CONNECTING.
//  CONNECTING: tx_enable=1, tx_send_fct=1; got_fct -> RUN; err|nchar|tc|expiry|link_disable
//    -> ERROR_RESET.
//  RUN: tx_enable=1, tx_send_fct=1; err|link_disable -> ERROR_RESET; nchar/tc accepted.
//  Priority per cycle: resetn > err > link_disable > forward event > timer expiry.
//  Event and expiry in the same cycle: event wins.
//  Credit (CONNECTING/RUN only): +8 per rx_got_fct, -1 per tx_nchar_sent; both same cycle = +7.
//  Result >MAX_CRED: credit violation, credit held.
//  Decrement at 0: credit violation, credit stays 0.
//  link_error asserted the cycle after any err-caused transition; not on link_disable or timeout
//    in READY.
//  link_disable in ERROR_WAIT/READY: no transition, only blocks READY->STARTED.
//  resetn low mid-state: immediate asynchronous return to reset values, timers cleared.
// STRUCTURE
//  Include file spw_link_defs.vh: state localparams, CRED_STEP=8, MAX_CRED default.
//  Sub-module spw_credit_counter: 6-bit add/sub, saturation, violation flag, synchronous clear.
//  Top holds FSM, state timer, disconnect counter, null_seen.
// TESTING
//  Reset release, link_start=1, NULL at ERROR_WAIT+10 ignored for state; READY at 640+1280;
//    STARTED next cycle; NULL -> CONNECTING; FCT -> RUN, tx_credit=8.
//  STARTED, no NULL for 1280 cycles -> ERROR_RESET, link_error=0, tx_enable=0.
//  RUN, rx_error pulse -> ERROR_RESET next edge, link_error=1 for 1 cycle, rx_resetn=0.
//  RUN, rx_got_bit stops for 85 cycles -> ERROR_RESET, link_error=1.
//  RUN, 7 FCTs -> credit 56; 8th FCT -> violation, ERROR_RESET.
//  RUN, FCT+nchar_sent same cycle from 10 -> 17.
//  auto_start=1, link_start=0, NULL in READY -> STARTED.
//  resetn pulsed low during CONNECTING -> all outputs at reset values immediately.

Source files
------------

// File: rtl/spw_link_fsm_pkg.sv
// Shared definitions for the SpaceWire link-interface FSM: state encoding,
// timing defaults and credit constants.
package spw_link_fsm_pkg;

  typedef enum logic [2:0] {
    ST_ERROR_RESET = 3'd0,
    ST_ERROR_WAIT  = 3'd1,
    ST_READY       = 3'd2,
    ST_STARTED     = 3'd3,
    ST_CONNECTING  = 3'd4,
    ST_RUN         = 3'd5
  } link_state_e;

  localparam int T_6U4_DEF    = 640;
  localparam int T_12U8_DEF   = 1280;
  localparam int T_DISC_DEF   = 85;
  localparam int MAX_CRED_DEF = 56;
  localparam int CRED_STEP    = 8;

  // Credit is only meaningful once FCTs may be exchanged.
  function automatic logic credit_active(input link_state_e s);
    return (s == ST_CONNECTING) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/spw_link_fsm_credit_counter.sv
// TX flow-control credit: +CRED_STEP per received FCT, -1 per sent N-Char,
// with overflow/underflow reported as a violation and the count held.
module spw_credit_counter
  import spw_link_fsm_pkg::*;
#(
  parameter int MAX_CRED = MAX_CRED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       add,
  input  logic       sub,
  output logic [5:0] credit,
  output logic       violation
);

  logic [6:0] sum;

  always_comb begin
    sum       = {1'b0, credit} + (add ? 7'(CRED_STEP) : 7'd0) - (sub ? 7'd1 : 7'd0);
    violation = 1'b0;
    if (enable) begin
      if (add && (sum > 7'(MAX_CRED))) begin
        violation = 1'b1;
      end else if (!add && sub && (credit == 6'd0)) begin
        violation = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= 6'd0;
    end else if (clear) begin
      credit <= 6'd0;
    end else if (enable && !violation && (add || sub)) begin
      credit <= sum[5:0];
    end
  end

endmodule

// File: rtl/spw_link_fsm.sv
// SpaceWire link-interface state machine: sequences RX reset and TX mode from
// RX events, host controls, a shared state timer and a disconnect detector.
module spw_link_fsm
  import spw_link_fsm_pkg::*;
#(
  parameter int T_6U4    = T_6U4_DEF,
  parameter int T_12U8   = T_12U8_DEF,
  parameter int T_DISC   = T_DISC_DEF,
  parameter int MAX_CRED = MAX_CRED_DEF
) (
  input  logic       pclk,
  input  logic       resetn,
  input  logic       link_start,
  input  logic       auto_start,
  input  logic       link_disable,
  input  logic       rx_got_bit,
  input  logic       rx_got_null,
  input  logic       rx_got_fct,
  input  logic       rx_got_nchar,
  input  logic       rx_got_time_code,
  input  logic       rx_error,
  input  logic       tx_nchar_sent,
  output logic       rx_resetn,
  output logic       tx_enable,
  output logic       tx_send_fct,
  output logic [5:0] tx_credit,
  output logic [2:0] link_state,
  output logic       link_error
);

  localparam int TW = $clog2(T_12U8);
  localparam int DW = $clog2(T_DISC);

  link_state_e   state;
  link_state_e   state_nxt;
  logic [TW-1:0] timer;
  logic [DW-1:0] idle_cnt;
  logic          null_seen;
  logic          disc_armed;
  logic          disc;
  logic          cred_viol;
  logic          err;
  logic          err_exit;
  logic          bad_char;
  logic          link_en;
  logic          expiry_short;
  logic          expiry_long;

  assign link_state = state;

  always_comb begin
    expiry_short = (timer == TW'(T_6U4 - 1));
    expiry_long  = (timer == TW'(T_12U8 - 1));
    disc_armed   = null_seen && (state != ST_ERROR_RESET);
    disc         = disc_armed && (idle_cnt == DW'(T_DISC - 1));
    err          = rx_error || disc || cred_viol;
    bad_char     = rx_got_fct || rx_got_nchar || rx_got_time_code;
    link_en      = !link_disable && (link_start || (auto_start && null_seen));
    state_nxt    = state;
    err_exit     = 1'b0;
    // Priority inside each state: err, link_disable, forward event, timer expiry.
    case (state)
      ST_ERROR_RESET: begin
        if (expiry_short) state_nxt = ST_ERROR_WAIT;
      end
      ST_ERROR_WAIT: begin
        if (err) begin
          state_nxt = ST_ERROR_RESET;
          err_exit  = 1'b1;
        end else if (bad_char) state_nxt = ST_ERROR_RESET;
        else if (expiry_long) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (err) begin
          state_nxt = ST_ERROR_RESET;
          err_exit  = 1'b1;
        end else if (bad_char) state_nxt = ST_ERROR_RESET;
        else if (link_en) state_nxt = ST_STARTED;
      end
      ST_STARTED: begin
        if (err) begin
          state_nxt = ST_ERROR_RESET;
          err_exit  = 1'b1;
        end else if (bad_char) state_nxt = ST_ERROR_RESET;
        else if (null_seen) state_nxt = ST_CONNECTING;
        else if (expiry_long) state_nxt = ST_ERROR_RESET;
      end
      ST_CONNECTING: begin
        if (err) begin
          state_nxt = ST_ERROR_RESET;
          err_exit  = 1'b1;
        end else if (link_disable) state_nxt = ST_ERROR_RESET;
        else if (rx_got_fct) state_nxt = ST_RUN;
        else if (rx_got_nchar || rx_got_time_code) state_nxt = ST_ERROR_RESET;
        else if (expiry_long) state_nxt = ST_ERROR_RESET;
      end
      ST_RUN: begin
        if (err) begin
          state_nxt = ST_ERROR_RESET;
          err_exit  = 1'b1;
        end else if (link_disable) state_nxt = ST_ERROR_RESET;
      end
      default: state_nxt = ST_ERROR_RESET;
    endcase
  end

  // Outputs are registered from the next state so they move with link_state.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_ERROR_RESET;
      timer       <= '0;
      idle_cnt    <= '0;
      null_seen   <= 1'b0;
      rx_resetn   <= 1'b0;
      tx_enable   <= 1'b0;
      tx_send_fct <= 1'b0;
      link_error  <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= (state_nxt != state) ? '0 : timer + 1'b1;
      if (state == ST_ERROR_RESET) begin
        null_seen <= 1'b0;
      end else if (rx_got_null) begin
        null_seen <= 1'b1;
      end
      if (!disc_armed || rx_got_bit || disc) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      rx_resetn   <= (state_nxt != ST_ERROR_RESET);
      tx_enable   <= (state_nxt == ST_STARTED) || credit_active(state_nxt);
      tx_send_fct <= credit_active(state_nxt);
      link_error  <= err_exit;
    end
  end

  spw_credit_counter #(
    .MAX_CRED(MAX_CRED)
  ) u_credit (
    .clk      (pclk),
    .rst_n    (resetn),
    .clear    (!credit_active(state_nxt)),
    .enable   (credit_active(state)),
    .add      (rx_got_fct),
    .sub      (tx_nchar_sent),
    .credit   (tx_credit),
    .violation(cred_viol)
  );

endmodule

// File: tb/tb_spw_link_fsm.sv
// Directed bench for spw_link_fsm: walks the link through start-up, credit,
// timeout, error, disconnect, auto-start and asynchronous reset scenarios.
module tb_spw_link_fsm;

  logic       pclk;
  logic       resetn;
  logic       link_start;
  logic       auto_start;
  logic       link_disable;
  logic       rx_got_bit;
  logic       rx_got_null;
  logic       rx_got_fct;
  logic       rx_got_nchar;
  logic       rx_got_time_code;
  logic       rx_error;
  logic       tx_nchar_sent;
  logic       rx_resetn;
  logic       tx_enable;
  logic       tx_send_fct;
  logic [5:0] tx_credit;
  logic [2:0] link_state;
  logic       link_error;

  // {link_state, rx_resetn, tx_enable, tx_send_fct, link_error, tx_credit}
  logic [12:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  spw_link_fsm dut (
    .pclk            (pclk),
    .resetn          (resetn),
    .link_start      (link_start),
    .auto_start      (auto_start),
    .link_disable    (link_disable),
    .rx_got_bit      (rx_got_bit),
    .rx_got_null     (rx_got_null),
    .rx_got_fct      (rx_got_fct),
    .rx_got_nchar    (rx_got_nchar),
    .rx_got_time_code(rx_got_time_code),
    .rx_error        (rx_error),
    .tx_nchar_sent   (tx_nchar_sent),
    .rx_resetn       (rx_resetn),
    .tx_enable       (tx_enable),
    .tx_send_fct     (tx_send_fct),
    .tx_credit       (tx_credit),
    .link_state      (link_state),
    .link_error      (link_error)
  );

  // clock / reset
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic check_head();
    logic [12:0] exp_v;
    logic [12:0] obs_v;
    string       tag;
    exp_v = exp_q.pop_front();
    tag   = tag_q.pop_front();
    obs_v = {link_state, rx_resetn, tx_enable, tx_send_fct, link_error, tx_credit};
    checks++;
    assert (obs_v === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed st=%0d rr=%b te=%b sf=%b le=%b cr=%0d expected st=%0d rr=%b te=%b sf=%b le=%b cr=%0d",
             tag, obs_v[12:10], obs_v[9], obs_v[8], obs_v[7], obs_v[6], obs_v[5:0],
             exp_v[12:10], exp_v[9], exp_v[8], exp_v[7], exp_v[6], exp_v[5:0]);
    end
  endtask

  // Queue the expected output vector, advance n edges, then compare.
  task automatic expect_after(input int n, input string tag, input logic [2:0] st,
                              input logic rr, input logic te, input logic sf,
                              input logic le, input logic [5:0] cr);
    exp_q.push_back({st, rr, te, sf, le, cr});
    tag_q.push_back(tag);
    step(n);
    check_head();
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int k = 0;
    while (link_state !== st && k < budget) begin
      step(1);
      k++;
    end
    checks++;
    assert (link_state === st)
    else begin
      errors++;
      $error("FAIL %s: observed state=%0d expected state=%0d within %0d cycles",
             tag, link_state, st, budget);
    end
  endtask

  task automatic reach_run();
    wait_state(3'd3, 2500, "reach_started");
    rx_got_null = 1'b1;
    expect_after(1, "started_null", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    rx_got_null = 1'b0;
    expect_after(1, "connecting", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
    rx_got_fct = 1'b1;
    expect_after(1, "run_entry", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 6'd8);
    rx_got_fct = 1'b0;
  endtask

  initial begin
    resetn           = 1'b0;
    link_start       = 1'b1;
    auto_start       = 1'b0;
    link_disable     = 1'b0;
    rx_got_bit       = 1'b1;
    rx_got_null      = 1'b0;
    rx_got_fct       = 1'b0;
    rx_got_nchar     = 1'b0;
    rx_got_time_code = 1'b0;
    rx_error         = 1'b0;
    tx_nchar_sent    = 1'b0;

    step(2);
    expect_after(0, "reset_vals", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    resetn = 1'b1;

    // Start-up: 640 cycles ERROR_RESET, 1280 ERROR_WAIT, then READY/STARTED.
    expect_after(639, "er_dwell_end", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    expect_after(1, "ew_entry", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    step(9);
    rx_got_null = 1'b1;
    expect_after(1, "null_in_ew", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    rx_got_null = 1'b0;
    expect_after(1269, "ew_dwell_end", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    expect_after(1, "ready", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    expect_after(1, "started", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    rx_got_null = 1'b1;
    expect_after(1, "first_connecting", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
    rx_got_null = 1'b0;
    rx_got_fct = 1'b1;
    expect_after(1, "first_run", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 6'd8);
    rx_got_fct = 1'b0;

    // Credit up to the ceiling, then one FCT too many.
    for (int i = 1; i <= 6; i++) begin
      rx_got_fct = 1'b1;
      expect_after(1, "fct_accum", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 6'(8 + 8 * i));
      rx_got_fct = 1'b0;
    end
    rx_got_fct = 1'b1;
    expect_after(1, "cred_overflow", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    rx_got_fct = 1'b0;
    expect_after(1, "overflow_err_end", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    // STARTED without a NULL times out quietly.
    wait_state(3'd3, 2500, "reach_started_to");
    expect_after(1279, "started_hold", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    expect_after(1, "started_timeout", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    // RX error in RUN.
    reach_run();
    rx_error = 1'b1;
    expect_after(1, "rx_error", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    rx_error = 1'b0;
    expect_after(1, "rx_error_end", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    // Disconnect: bit activity stops in RUN.
    reach_run();
    rx_got_bit = 1'b0;
    expect_after(84, "idle_84", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 6'd8);
    expect_after(1, "disconnect", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    rx_got_bit = 1'b1;

    // Credit arithmetic 16 -> 10 -> 17, then link_disable.
    reach_run();
    rx_got_fct = 1'b1;
    expect_after(1, "fct_to_16", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 6'd16);
    rx_got_fct = 1'b0;
    tx_nchar_sent = 1'b1;
    expect_after(6, "nchar_to_10", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 6'd10);
    rx_got_fct = 1'b1;
    expect_after(1, "fct_and_nchar", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 6'd17);
    rx_got_fct    = 1'b0;
    tx_nchar_sent = 1'b0;
    link_disable  = 1'b1;
    expect_after(1, "link_disable", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    link_disable = 1'b0;

    // Auto-start: READY waits for a NULL, then asynchronous reset in CONNECTING.
    link_start = 1'b0;
    auto_start = 1'b1;
    wait_state(3'd2, 2500, "reach_ready");
    expect_after(5, "ready_hold", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    rx_got_null = 1'b1;
    expect_after(1, "ready_null", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    rx_got_null = 1'b0;
    expect_after(1, "auto_started", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    expect_after(1, "auto_connecting", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
    resetn = 1'b0;
    expect_after(0, "async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    resetn = 1'b1;
    expect_after(1, "after_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
